// File: rtl/tl_seq_pkg.sv
// Shared constants for the traffic-light sequencing core: FSM state codes
// and the 6-bit lamp patterns, ordered {ra, ya, ga, rb, yb, gb}.
package tl_seq_pkg;

  localparam logic [2:0] ST_START = 3'b111;
  localparam logic [2:0] ST_NS    = 3'b011;
  localparam logic [2:0] ST_NY    = 3'b010;
  localparam logic [2:0] ST_EW    = 3'b000;
  localparam logic [2:0] ST_EY    = 3'b001;

  localparam logic [5:0] LAMP_START = 6'b100100;
  localparam logic [5:0] LAMP_NS    = 6'b001100;
  localparam logic [5:0] LAMP_NY    = 6'b010100;
  localparam logic [5:0] LAMP_EW    = 6'b100001;
  localparam logic [5:0] LAMP_EY    = 6'b100010;
  // Illegal codes show both directions red, same as START.
  localparam logic [5:0] LAMP_SAFE  = 6'b100100;

  function automatic logic [5:0] lamp_of(input logic [2:0] st);
    logic [5:0] lamp;
    lamp = LAMP_SAFE;
    case (st)
      ST_START: lamp = LAMP_START;
      ST_NS:    lamp = LAMP_NS;
      ST_NY:    lamp = LAMP_NY;
      ST_EW:    lamp = LAMP_EW;
      ST_EY:    lamp = LAMP_EY;
      default:  lamp = LAMP_SAFE;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/tl_seq_tick_div.sv
// Slow-tick divider. The counter runs 0..COMPARE and toggles a phase bit on
// each wrap; o_tick is a registered one-clock pulse following every rising
// phase edge, giving one tick per 2*(COMPARE+1) clocks. The tick is used as
// a clock enable downstream, never as a clock.
module tl_seq_tick_div
  import tl_seq_pkg::*;
#(
  parameter int COMPARE = 2500000 - 1,
  parameter int WIDTH   = 22
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam logic [WIDTH-1:0] CMP = WIDTH'(COMPARE);

  logic [WIDTH-1:0] cnt;
  logic             phase;
  logic             phase_d;

  // Count 0..COMPARE, wrap and toggle the slow phase at terminal count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CMP) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Rising-edge detect on the phase, registered into a single-clock pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_d <= 1'b0;
      o_tick  <= 1'b0;
    end else begin
      phase_d <= phase;
      o_tick  <= phase & ~phase_d;
    end
  end

endmodule

// File: rtl/tl_seq_core.sv
// Traffic-light sequencing core. Steps START -> NS -> NY -> EW -> EY -> NS ...
// once per slow tick, dwelling a programmable number of ticks in each state.
// Optional macro TLSEQ_LIGHTS_EN adds registered lamp outputs that follow
// o_state by one clock.
//
//  state | meaning
//  ------+--------------------------------------------
//  START | post-reset, all red for one tick (3'b111)
//  NS    | north/south green               (3'b011)
//  NY    | north/south yellow              (3'b010)
//  EW    | east/west green                 (3'b000)
//  EY    | east/west yellow                (3'b001)
module tl_seq_core
  import tl_seq_pkg::*;
#(
  parameter int                  COMPARE = 2500000 - 1,
  parameter int                  WIDTH   = 22,
  parameter int                  T_WIDTH = 12,
  parameter logic [T_WIDTH-1:0]  NS_TIME = T_WIDTH'(90),
  parameter logic [T_WIDTH-1:0]  EW_TIME = T_WIDTH'(60),
  parameter logic [T_WIDTH-1:0]  Y_TIME  = T_WIDTH'(30)
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [2:0] o_state,
  output logic       o_tick
`ifdef TLSEQ_LIGHTS_EN
  ,
  output logic       o_reda,
  output logic       o_yellowa,
  output logic       o_greena,
  output logic       o_redb,
  output logic       o_yellowb,
  output logic       o_greenb
`endif
);

  localparam logic [T_WIDTH-1:0] ONE = T_WIDTH'(1);

  // A programmed time of zero still holds the state for one tick.
  function automatic logic [T_WIDTH-1:0] eff_time(input logic [T_WIDTH-1:0] t);
    return (t == '0) ? ONE : t;
  endfunction

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [T_WIDTH-1:0] tcnt;
  logic [T_WIDTH-1:0] dwell;
  logic               legal;
  logic               tick;

  tl_seq_tick_div #(
    .COMPARE (COMPARE),
    .WIDTH   (WIDTH)
  ) u_tick_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  assign o_tick  = tick;
  assign o_state = state;

  // Successor state and dwell length of the current state.
  always_comb begin
    state_nxt = ST_START;
    dwell     = ONE;
    legal     = 1'b1;
    case (state)
      ST_START: begin state_nxt = ST_NS; dwell = ONE;               end
      ST_NS:    begin state_nxt = ST_NY; dwell = eff_time(NS_TIME); end
      ST_NY:    begin state_nxt = ST_EW; dwell = eff_time(Y_TIME);  end
      ST_EW:    begin state_nxt = ST_EY; dwell = eff_time(EW_TIME); end
      ST_EY:    begin state_nxt = ST_NS; dwell = eff_time(Y_TIME);  end
      default:  begin state_nxt = ST_START; dwell = ONE; legal = 1'b0; end
    endcase
  end

  // State and tick timer advance only on slow ticks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_START;
      tcnt  <= '0;
    end else if (tick) begin
      if (!legal) begin
        state <= ST_START;
        tcnt  <= '0;
      end else if (tcnt == dwell - ONE) begin
        state <= state_nxt;
        tcnt  <= '0;
      end else begin
        tcnt  <= tcnt + ONE;
      end
    end
  end

`ifdef TLSEQ_LIGHTS_EN
  logic [5:0] lamps;

  // Lamp drivers are registered from the state, one clock behind o_state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lamps <= LAMP_START;
    end else begin
      lamps <= lamp_of(state);
    end
  end

  assign {o_reda, o_yellowa, o_greena, o_redb, o_yellowb, o_greenb} = lamps;
`endif

endmodule

// File: tb/tb_tl_seq_core.sv
// Bench for tl_seq_core: two instances (EW_TIME=2 and EW_TIME=0) driven by a
// shared clock/reset, checked every cycle against a tick-schedule and
// dwell-count reference model, with randomized run lengths and asynchronous
// reset drops (some deliberately while in EW).
module tb_tl_seq_core;

  localparam int C  = 1;
  localparam int P  = 2 * (C + 1);
  localparam int NS = 3;
  localparam int Y  = 1;

  logic       clk;
  logic       rst_n;
  logic [2:0] st_a, st_b;
  logic       tk_a, tk_b;
`ifdef TLSEQ_LIGHTS_EN
  logic ra_a, ya_a, ga_a, rb_a, yb_a, gb_a;
  logic ra_b, ya_b, ga_b, rb_b, yb_b, gb_b;
`endif

  tl_seq_core #(
    .COMPARE(C), .WIDTH(2), .T_WIDTH(4),
    .NS_TIME(4'd3), .EW_TIME(4'd2), .Y_TIME(4'd1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_state(st_a), .o_tick(tk_a)
`ifdef TLSEQ_LIGHTS_EN
    , .o_reda(ra_a), .o_yellowa(ya_a), .o_greena(ga_a),
    .o_redb(rb_a), .o_yellowb(yb_a), .o_greenb(gb_a)
`endif
  );

  tl_seq_core #(
    .COMPARE(C), .WIDTH(2), .T_WIDTH(4),
    .NS_TIME(4'd3), .EW_TIME(4'd0), .Y_TIME(4'd1)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_state(st_b), .o_tick(tk_b)
`ifdef TLSEQ_LIGHTS_EN
    , .o_reda(ra_b), .o_yellowa(ya_b), .o_greena(ga_b),
    .o_redb(rb_b), .o_yellowb(yb_b), .o_greenb(gb_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, "at_start" or a position in the NS,NY,EW,EY loop.
  bit         at_s [2];
  int         pos  [2];
  int         tc   [2];
  int         ew_t [2];
  int         n;
  bit         exp_tick;
  bit         in_reset;
  logic [2:0] loop_code [4];
  logic [5:0] loop_lamp [4];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, n);
    end
  endtask

  function automatic int dwell_of(input int m);
    int t;
    if (at_s[m]) return 1;
    case (pos[m])
      0: t = NS;
      1: t = Y;
      2: t = ew_t[m];
      default: t = Y;
    endcase
    return (t == 0) ? 1 : t;
  endfunction

  function automatic logic [2:0] code_of(input int m);
    return at_s[m] ? 3'b111 : loop_code[pos[m]];
  endfunction

  function automatic logic [5:0] lamp_ref(input int m);
    return at_s[m] ? 6'b100100 : loop_lamp[pos[m]];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      at_s[m] = 1'b1;
      pos[m]  = 0;
      tc[m]   = 0;
    end
    n        = 0;
    exp_tick = 1'b0;
  endtask

  task automatic advance(input int m);
    tc[m]++;
    if (tc[m] == dwell_of(m)) begin
      tc[m] = 0;
      if (at_s[m]) begin
        at_s[m] = 1'b0;
        pos[m]  = 0;
      end else begin
        pos[m] = (pos[m] + 1) % 4;
      end
    end
  endtask

  // One clock: update model for the edge, then compare every output.
  task automatic step();
    logic [5:0] lamp_exp [2];
    @(posedge clk);
    #1;
    if (in_reset) begin
      lamp_exp[0] = 6'b100100;
      lamp_exp[1] = 6'b100100;
      check("rst_state_a", {5'd0, st_a}, 8'h07);
      check("rst_state_b", {5'd0, st_b}, 8'h07);
      check("rst_tick_a",  {7'd0, tk_a}, 8'h00);
      check("rst_tick_b",  {7'd0, tk_b}, 8'h00);
    end else begin
      lamp_exp[0] = lamp_ref(0);
      lamp_exp[1] = lamp_ref(1);
      if (exp_tick) begin
        advance(0);
        advance(1);
      end
      n++;
      exp_tick = (n >= C + 2) && (((n - (C + 2)) % P) == 0);
      check("state_a", {5'd0, st_a}, {5'd0, code_of(0)});
      check("state_b", {5'd0, st_b}, {5'd0, code_of(1)});
      check("tick_a",  {7'd0, tk_a}, {7'd0, exp_tick});
      check("tick_b",  {7'd0, tk_b}, {7'd0, exp_tick});
    end
`ifdef TLSEQ_LIGHTS_EN
    check("lamps_a", {2'd0, ra_a, ya_a, ga_a, rb_a, yb_a, gb_a}, {2'd0, lamp_exp[0]});
    check("lamps_b", {2'd0, ra_b, ya_b, ga_b, rb_b, yb_b, gb_b}, {2'd0, lamp_exp[1]});
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int len;
    int guard;
    loop_code[0] = 3'b011; loop_code[1] = 3'b010;
    loop_code[2] = 3'b000; loop_code[3] = 3'b001;
    loop_lamp[0] = 6'b001100; loop_lamp[1] = 6'b010100;
    loop_lamp[2] = 6'b100001; loop_lamp[3] = 6'b100010;
    ew_t[0] = 2;
    ew_t[1] = 0;
    model_reset();

    rst_n    = 1'b0;
    in_reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    release_reset();

    // A full deterministic pass covers START, two NS->EY loops and the zero-time EW.
    for (int i = 0; i < 70; i++) step();

    for (int seg = 0; seg < 6; seg++) begin
      len = $urandom_range(60, 12);
      for (int i = 0; i < len; i++) step();
      if (seg % 2 == 1) begin
        guard = 0;
        while (code_of(0) != 3'b000 && guard < 100) begin
          step();
          guard++;
        end
        check("ew_reached", {7'd0, (code_of(0) == 3'b000)}, 8'h01);
      end
      // Asynchronous drop between clock edges; outputs must react immediately.
      #($urandom_range(3, 1));
      rst_n    = 1'b0;
      in_reset = 1'b1;
      #1;
      check("async_state_a", {5'd0, st_a}, 8'h07);
      check("async_state_b", {5'd0, st_b}, 8'h07);
      check("async_tick_a",  {7'd0, tk_a}, 8'h00);
`ifdef TLSEQ_LIGHTS_EN
      check("async_lamps_a", {2'd0, ra_a, ya_a, ga_a, rb_a, yb_a, gb_a}, 8'h24);
`endif
      len = $urandom_range(4, 1);
      for (int i = 0; i < len; i++) step();
      release_reset();
    end

    for (int i = 0; i < 40; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
